// File: rtl/pe_result_drain_if.sv
// Handshake bundle between the PE array result ports, the drain block and the output buffer.
// The drain block uses the slave view. The source/sink side uses the master view.
interface pe_result_drain_if #(
    parameter int num = 4,
    parameter int DW  = 32
);
    logic                         in_valid;
    logic [num-1:0][DW-1:0]       in_result;
    logic                         transpose;
    logic                         out_valid;
    logic                         out_ready;
    logic [num-1:0][DW-1:0]       out_row;
    logic [$clog2(num)-1:0]       out_index;
    logic                         out_last;

    modport slave (
        input  in_valid, in_result, transpose, out_ready,
        output out_valid, out_row, out_index, out_last
    );

    modport master (
        output in_valid, in_result, transpose, out_ready,
        input  out_valid, out_row, out_index, out_last
    );
endinterface

// File: rtl/pe_result_drain.sv
// De-skews parallelogram-aligned result lanes from the PE array into a num x num matrix.
// It then presents the matrix row by row (or column by column) over a valid/ready handshake.
module pe_result_drain #(
    parameter int num = 4,
    parameter int DW  = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    pe_result_drain_if.slave       bus,
    output logic                   busy,
    output logic                   done,
    output logic                   overrun
);
    localparam int CW = $clog2(2 * num - 1);
    localparam int IW = $clog2(num);
    localparam logic [CW-1:0] LAST_BEAT = CW'(2 * num - 2);
    localparam logic [IW-1:0] LAST_ROW  = IW'(num - 1);

    typedef enum logic [1:0] {IDLE, COLLECT, DRAIN} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   c_q, c_d;
    logic [IW-1:0]   i_q, i_d;
    logic            tp_q, tp_d;
    logic            done_q, done_d;
    logic            overrun_q, overrun_d;
    logic            accept;

    logic [DW-1:0]   mat_q [num][num];
    logic [num-1:0]  lane_hit;
    logic [IW-1:0]   lane_row [num];
    logic [num-1:0][DW-1:0] row_w;

    always_comb begin
        state_d   = state_q;
        c_d       = c_q;
        i_d       = i_q;
        tp_d      = tp_q;
        done_d    = 1'b0;
        overrun_d = overrun_q;
        accept    = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    accept  = 1'b1;
                    tp_d    = bus.transpose;
                    c_d     = CW'(1);
                    state_d = COLLECT;
                end
            end
            COLLECT: begin
                if (bus.in_valid) begin
                    accept = 1'b1;
                    if (c_q == LAST_BEAT) begin
                        state_d = DRAIN;
                        c_d     = '0;
                        i_d     = '0;
                    end else begin
                        c_d = c_q + CW'(1);
                    end
                end
            end
            DRAIN: begin
                // Beats arriving while draining are dropped; only flagged.
                if (bus.in_valid) overrun_d = 1'b1;
                if (bus.out_ready) begin
                    if (i_q == LAST_ROW) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                        i_d     = '0;
                    end else begin
                        i_d = i_q + IW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= IDLE;
            c_q       <= '0;
            i_q       <= '0;
            tp_q      <= 1'b0;
            done_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            c_q       <= c_d;
            i_q       <= i_d;
            tp_q      <= tp_d;
            done_q    <= done_d;
            overrun_q <= overrun_d;
        end
    end

    // Lane k on beat c holds row c-k; the extra MSB of diff catches c < k.
    generate
        for (genvar gi = 0; gi < num; gi++) begin : g_lane
            logic [CW:0] diff;
            assign diff          = {1'b0, c_q} - (CW + 1)'(gi);
            assign lane_hit[gi]  = accept && !diff[CW] && (diff[CW-1:0] < CW'(num));
            assign lane_row[gi]  = IW'(diff[CW-1:0]);
        end
    endgenerate

    always_ff @(posedge clk) begin
        for (int k = 0; k < num; k++) begin
            if (lane_hit[k]) mat_q[lane_row[k]][k] <= bus.in_result[k];
        end
    end

    generate
        for (genvar gi = 0; gi < num; gi++) begin : g_out
            assign row_w[gi] = (state_q != DRAIN) ? '0 :
                               tp_q ? mat_q[gi][i_q] : mat_q[i_q][gi];
        end
    endgenerate

    assign bus.out_valid = (state_q == DRAIN);
    assign bus.out_row   = row_w;
    assign bus.out_index = (state_q == DRAIN) ? i_q : '0;
    assign bus.out_last  = (state_q == DRAIN) && (i_q == LAST_ROW);
    assign busy          = (state_q != IDLE);
    assign done          = done_q;
    assign overrun       = overrun_q;
endmodule

// File: tb/tb_pe_result_drain.sv
// Directed bench for pe_result_drain. It feeds skewed matrices and checks the de-skewed rows,
// the handshake timing, overrun, back-to-back offloads and reset abort.
module tb_pe_result_drain;
    localparam int N  = 4;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic reset;
    logic busy, done, overrun;

    pe_result_drain_if #(.num(N), .DW(DW)) bus();

    pe_result_drain #(.num(N), .DW(DW)) dut (
        .clk     (clk),
        .reset   (reset),
        .bus     (bus),
        .busy    (busy),
        .done    (done),
        .overrun (overrun)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int m [N][N];

    task automatic chk(input string tag, input logic [N*DW-1:0] obs, input logic [N*DW-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [N*DW-1:0] beat(input int c);
        logic [N*DW-1:0] v;
        for (int k = 0; k < N; k++) begin
            int r;
            r = c - k;
            if (r >= 0 && r < N) v[k*DW +: DW] = m[r][k];
            else                 v[k*DW +: DW] = 32'hBAD0_0000 + 32'(c * 16 + k);
        end
        return v;
    endfunction

    function automatic logic [N*DW-1:0] exp_row(input int i, input bit tp);
        logic [N*DW-1:0] v;
        for (int k = 0; k < N; k++) v[k*DW +: DW] = tp ? m[k][i] : m[i][k];
        return v;
    endfunction

    // Beat 0 is taken on the first edge; transpose is flipped on later beats to prove it is ignored.
    task automatic feed(input bit tp, input bit stall);
        for (int c = 0; c <= 2 * N - 2; c++) begin
            bus.in_valid  = 1'b1;
            bus.in_result = beat(c);
            bus.transpose = (c == 0) ? tp : ~tp;
            step();
            chk($sformatf("collect_busy_c%0d", c), busy, 1'b1);
            chk($sformatf("collect_valid_c%0d", c), bus.out_valid, (c == 2 * N - 2));
            if (stall && c == 3) begin
                bus.in_valid  = 1'b0;
                bus.in_result = '1;
                repeat (2) begin
                    step();
                    chk("stall_in_valid", bus.out_valid, 1'b0);
                end
            end
        end
        bus.in_valid  = 1'b0;
        bus.transpose = 1'b0;
        $display("offload fed tp=%0d stall=%0d", tp, stall);
    endtask

    task automatic drain(input bit tp, input int stall_idx, input int ovr_idx, input int abort_after);
        for (int i = 0; i < N; i++) begin
            chk($sformatf("valid_i%0d", i), bus.out_valid, 1'b1);
            chk($sformatf("index_i%0d", i), bus.out_index, i[1:0]);
            chk($sformatf("last_i%0d", i), bus.out_last, (i == N - 1));
            chk($sformatf("row_i%0d", i), bus.out_row, exp_row(i, tp));
            $display("row %0d: %h", i, bus.out_row);
            if (i == stall_idx) begin
                bus.out_ready = 1'b0;
                repeat (3) begin
                    step();
                    chk("stall_valid", bus.out_valid, 1'b1);
                    chk("stall_index", bus.out_index, i[1:0]);
                    chk("stall_row", bus.out_row, exp_row(i, tp));
                end
            end
            if (i == ovr_idx) begin
                bus.in_valid  = 1'b1;
                bus.in_result = '1;
            end
            bus.out_ready = 1'b1;
            step();
            bus.in_valid = 1'b0;
            if (i == ovr_idx) chk("overrun_set", overrun, 1'b1);
            if (i == abort_after) begin
                reset = 1'b0;
                step();
                chk("abort_valid", bus.out_valid, 1'b0);
                chk("abort_row", bus.out_row, '0);
                chk("abort_index", bus.out_index, '0);
                chk("abort_last", bus.out_last, 1'b0);
                chk("abort_busy", busy, 1'b0);
                chk("abort_overrun", overrun, 1'b0);
                reset = 1'b1;
                step();
                chk("abort_no_done", done, 1'b0);
                $display("offload aborted by reset after index %0d", i);
                return;
            end
            if (i < N - 1) chk($sformatf("no_early_done_i%0d", i), done, 1'b0);
        end
        chk("done_pulse", done, 1'b1);
        chk("done_idle", busy, 1'b0);
        chk("done_valid_low", bus.out_valid, 1'b0);
        $display("offload drained tp=%0d", tp);
    endtask

    initial begin
        reset         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_result = '0;
        bus.transpose = 1'b0;
        bus.out_ready = 1'b1;
        repeat (2) step();
        chk("rst_valid", bus.out_valid, 1'b0);
        chk("rst_row", bus.out_row, '0);
        chk("rst_index", bus.out_index, '0);
        chk("rst_last", bus.out_last, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_overrun", overrun, 1'b0);
        reset = 1'b1;
        step();

        // Basic
        for (int r = 0; r < N; r++) for (int k = 0; k < N; k++) m[r][k] = 16 * r + k;
        feed(1'b0, 1'b0);
        drain(1'b0, -1, -1, -1);
        step();
        chk("done_one_cycle", done, 1'b0);

        // Transpose
        feed(1'b1, 1'b0);
        drain(1'b1, -1, -1, -1);
        step();

        // Input stall and output backpressure on index 1
        feed(1'b0, 1'b1);
        drain(1'b0, 1, -1, -1);
        step();

        // Negative values, bit-exact
        for (int r = 0; r < N; r++) for (int k = 0; k < N; k++) m[r][k] = -(r + 1) * (k + 1);
        feed(1'b0, 1'b0);
        chk("neg_corner", bus.out_row, {32'hFFFFFFFC, 32'hFFFFFFFD, 32'hFFFFFFFE, 32'hFFFFFFFF});
        drain(1'b0, -1, -1, -1);
        step();

        // Overrun during drain, then the next offload starts in the done cycle
        for (int r = 0; r < N; r++) for (int k = 0; k < N; k++) m[r][k] = 100 + 16 * r + k;
        feed(1'b0, 1'b0);
        drain(1'b0, -1, 1, -1);
        for (int r = 0; r < N; r++) for (int k = 0; k < N; k++) m[r][k] = 7 * r + 3 * k + 5;
        feed(1'b0, 1'b0);
        drain(1'b0, -1, -1, -1);
        chk("overrun_sticky", overrun, 1'b1);
        step();

        // Reset mid-drain, then a fresh offload
        feed(1'b0, 1'b0);
        drain(1'b0, -1, -1, 1);
        for (int r = 0; r < N; r++) for (int k = 0; k < N; k++) m[r][k] = 1000 * (r + 1) - k;
        feed(1'b1, 1'b0);
        drain(1'b1, -1, -1, -1);
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
